instruction_fetch: RTL

Front-end fetch stage of the MIPS pipeline. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents each fetched instruction with its PC+4 to the IF/ID pipeline register. It absorbs decode back-pressure with a one-entry skid buffer and redirects on taken branches/jumps, discarding any in-flight fetch.

---
 rtl/instruction_fetch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC, reads instruction memory over req/ack and feeds IF/ID through a one-entry skid buffer.
// Define IF_MISALIGN_TRAP_EN to trap on misaligned redirect targets instead of silently aligning them.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] next_instruction,
    output logic [31:0] supposed_next_address,
    output logic        instr_valid,
    output logic        misaligned
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        FLUSH
`ifdef IF_MISALIGN_TRAP_EN
        , TRAP
`endif
    } fetch_state_t;

    fetch_state_t state, next_state;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] flush_addr;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_next;
    logic [31:0] target_load;
    logic        target_bad;

    assign pc_plus4 = pc + 32'd4;

`ifdef IF_MISALIGN_TRAP_EN
    logic misaligned_flag;
    assign target_load = branch_target;
    assign target_bad  = branch_taken && (branch_target[1:0] != 2'b00);
    assign misaligned  = misaligned_flag;
`else
    assign target_load = branch_target & ~32'h0000_0003;
    assign target_bad  = 1'b0;
    assign misaligned  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // A full skid buffer suppresses new requests; FLUSH keeps the abandoned request alive on its original address.
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        imem_addr  = pc;
        case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                imem_req = !skid_valid;
                if (branch_taken) begin
                    if (imem_req && !imem_ack) next_state = FLUSH;
`ifdef IF_MISALIGN_TRAP_EN
                    if (target_bad) next_state = TRAP;
`endif
                end
            end
            FLUSH: begin
                imem_req  = 1'b1;
                imem_addr = flush_addr;
                if (imem_ack) next_state = FETCH;
`ifdef IF_MISALIGN_TRAP_EN
                if (target_bad) next_state = TRAP;
`endif
            end
            default: begin
                next_state = state;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc                    <= RESET_PC;
            flush_addr            <= 32'd0;
            next_instruction      <= 32'd0;
            supposed_next_address <= 32'd0;
            instr_valid           <= 1'b0;
            skid_valid            <= 1'b0;
            skid_instr            <= 32'd0;
            skid_next             <= 32'd0;
`ifdef IF_MISALIGN_TRAP_EN
            misaligned_flag       <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken) begin
                        pc          <= target_load;
                        instr_valid <= 1'b0;
                        skid_valid  <= 1'b0;
                        if (imem_req && !imem_ack) flush_addr <= pc;
`ifdef IF_MISALIGN_TRAP_EN
                        if (target_bad) misaligned_flag <= 1'b1;
`endif
                    end else if (skid_valid) begin
                        if (!stall) begin
                            next_instruction      <= skid_instr;
                            supposed_next_address <= skid_next;
                            instr_valid           <= 1'b1;
                            skid_valid            <= 1'b0;
                        end
                    end else if (imem_req && imem_ack) begin
                        pc <= pc_plus4;
                        if (instr_valid && stall) begin
                            skid_instr <= imem_rdata;
                            skid_next  <= pc_plus4;
                            skid_valid <= 1'b1;
                        end else begin
                            next_instruction      <= imem_rdata;
                            supposed_next_address <= pc_plus4;
                            instr_valid           <= 1'b1;
                        end
                    end else if (!stall) begin
                        instr_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (branch_taken) begin
                        pc <= target_load;
`ifdef IF_MISALIGN_TRAP_EN
                        if (target_bad) misaligned_flag <= 1'b1;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
